data_mem_responder: RTL

- Responder (memory side) of the core's data memory interface: accepts `data_req`/`data_gnt` requests from the core's memory stage and serves word-organised RAM storage with byte-enable writes.
- Returns an `rvalid` response for every granted transfer.
- Sits at the top level between the core data port and on-chip data RAM.
- Provides an optional wait-state generator for exercising core stall paths.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 115 +++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Core data-port bus between the core memory stage (master) and the data RAM responder (slave).
// Signal names follow the responder's point of view (_i into the responder, _o out of it).
interface data_mem_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BE_WIDTH   = 4
);
   logic                  data_req_i;
   logic [ADDR_WIDTH-1:0] data_addr_i;
   logic                  data_wr_i;
   logic [BE_WIDTH-1:0]   data_be_i;
   logic [DATA_WIDTH-1:0] data_wdata_i;
   logic                  data_gnt_o;
   logic                  data_rvalid_o;
   logic [DATA_WIDTH-1:0] data_rdata_o;

   modport master (
      output data_req_i, data_addr_i, data_wr_i, data_be_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o
   );

   modport slave (
      input  data_req_i, data_addr_i, data_wr_i, data_be_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: word RAM with byte-enable writes and one-cycle rvalid per grant.
// Define DMEM_WAIT_STATES_EN to add a request-to-grant wait-state generator (WAIT_STATES cycles).
module data_mem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int BE_WIDTH    = 4,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input logic                clk,
   input logic                rst_n,
   data_mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rvalid;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_gnt;
   logic                  w_gnt_out;
   logic                  w_xfer;
   logic                  w_unused_addr;

   // Byte offset and bits above the RAM size are dropped, so the space wraps.
   assign w_idx         = bus.data_addr_i[IDX_W+1:2];
   assign w_unused_addr = ^{bus.data_addr_i[ADDR_WIDTH-1:IDX_W+2], bus.data_addr_i[1:0]};

`ifdef DMEM_WAIT_STATES_EN
   // state   | meaning
   // ST_IDLE | no request pending; a new request loads the counter
   // ST_WAIT | request seen, counting down to the grant cycle
   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   localparam bit         LP_WS_ON   = (WAIT_STATES > 0);
   localparam logic [3:0] LP_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t     r_state;
   logic [3:0] r_cnt;

   // Counter is loaded with WAIT_STATES-1 so the grant lands WAIT_STATES cycles after first sight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.data_req_i && LP_WS_ON) begin
                  r_cnt   <= LP_WS_LOAD;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!bus.data_req_i) begin
                  r_cnt   <= 4'd0;
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_cnt   <= 4'd0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_gnt = 1'b0;
      case (r_state)
         ST_IDLE: w_gnt = bus.data_req_i & ~LP_WS_ON;
         ST_WAIT: w_gnt = bus.data_req_i & (r_cnt == 4'd0);
         default: w_gnt = 1'b0;
      endcase
   end
`else
   localparam int unused_wait_states = WAIT_STATES;

   assign w_gnt = bus.data_req_i;
`endif

   // Grant is forced low while reset is held, independent of the request.
   assign w_gnt_out = w_gnt & rst_n;
   assign w_xfer    = bus.data_req_i & w_gnt_out;

   always_ff @(posedge clk) begin
      if (w_xfer && bus.data_wr_i) begin
         for (int n = 0; n < BE_WIDTH; n++) begin
            if (bus.data_be_i[n]) begin
               r_mem[w_idx][8*n +: 8] <= bus.data_wdata_i[8*n +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_xfer;
         if (w_xfer) begin
            r_rdata <= bus.data_wr_i ? '0 : r_mem[w_idx];
         end
      end
   end

   assign bus.data_gnt_o    = w_gnt_out;
   assign bus.data_rvalid_o = r_rvalid;
   assign bus.data_rdata_o  = r_rdata;
endmodule
